// File: rtl/word_encoder_pkg.sv
// Shared widths, FSM state type and word folding for the word encoder.
// Define WORD_ENCODER_SATURATE_EN to clamp oversized results to the word maximum.
package enc_pkg;

    localparam int W_WIDTH    = 13;
    localparam int AB_WIDTH   = 7;
    localparam int ACC_WIDTH  = 14;
    localparam int MUL_CYCLES = 7;
    localparam int CNT_WIDTH  = 3;

    localparam logic [W_WIDTH-1:0] W_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ADD,
        FIN
    } enc_state_t;

    // Folds the 14-bit accumulator result into a word, flagging overflow when clamped.
    function automatic logic [W_WIDTH-1:0] fold_word(input logic [ACC_WIDTH-1:0] v,
                                                     output logic ovf);
`ifdef WORD_ENCODER_SATURATE_EN
        ovf = (v > ACC_WIDTH'(W_MAX));
        return ovf ? W_MAX : W_WIDTH'(v);
`else
        ovf = 1'b0;
        return W_WIDTH'(v);
`endif
    endfunction

endpackage

// File: rtl/word_encoder_if.sv
// Request/result bundle between a word encoder client and the encoder.
interface word_encoder_if;

    logic                          start;
    logic [enc_pkg::AB_WIDTH-1:0]  A_val;
    logic [enc_pkg::AB_WIDTH-1:0]  B_val;
    logic [enc_pkg::W_WIDTH-1:0]   W;
    logic                          busy;
    logic                          done;
    logic                          err;

    modport master (
        output start, A_val, B_val,
        input  W, busy, done, err
    );

    modport slave (
        input  start, A_val, B_val,
        output W, busy, done, err
    );

endinterface

// File: rtl/word_encoder_shift_add_mul.sv
// Shift-add multiplier: accumulates A*RADIX one A bit per step, LSB first,
// and presents acc + B combinationally for the final add.
module shift_add_mul
    import enc_pkg::*;
#(
    parameter int RADIX = 60
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [AB_WIDTH-1:0]  a_in,
    input  logic [AB_WIDTH-1:0]  b_in,
    output logic [ACC_WIDTH-1:0] sum
);

    localparam logic [AB_WIDTH-1:0] MCAND = AB_WIDTH'(RADIX);

    logic [AB_WIDTH-1:0]  a_q,   a_d;
    logic [AB_WIDTH-1:0]  b_q,   b_d;
    logic [ACC_WIDTH-1:0] m_q,   m_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;

    // The multiplicand shifts left in step with A shifting right, so bit i of A adds RADIX<<i.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        m_d   = m_q;
        acc_d = acc_q;
        if (load) begin
            a_d   = a_in;
            b_d   = b_in;
            m_d   = ACC_WIDTH'(MCAND);
            acc_d = '0;
        end else if (step) begin
            a_d = a_q >> 1;
            m_d = m_q << 1;
            if (a_q[0]) begin
                acc_d = acc_q + m_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            m_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            m_q   <= m_d;
            acc_q <= acc_d;
        end
    end

    assign sum = acc_q + ACC_WIDTH'(b_q);

endmodule

// File: rtl/word_encoder.sv
// Word encoder W = A*RADIX + B with fixed 9-cycle latency and registered outputs.
// Overflow handling follows WORD_ENCODER_SATURATE_EN (clamp) or wraps modulo 8192.
module word_encoder
    import enc_pkg::*;
#(
    parameter int RADIX = 60
) (
    input  logic          clk,
    input  logic          reset,
    word_encoder_if.slave bus
);

    localparam logic [AB_WIDTH-1:0]  RADIX_V  = AB_WIDTH'(RADIX);
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(MUL_CYCLES - 1);

    enc_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic [W_WIDTH-1:0]   w_q,     w_d;
    logic                 err_q,   err_d;
    logic                 done_q,  done_d;
    logic                 busy_q,  busy_d;
    logic                 bad_q,   bad_d;
    logic                 ovf_q,   ovf_d;

    logic                 load;
    logic                 step;
    logic [ACC_WIDTH-1:0] sum;
    logic [W_WIDTH-1:0]   folded;
    logic                 fold_ovf;

    shift_add_mul #(
        .RADIX (RADIX)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .a_in  (bus.A_val),
        .b_in  (bus.B_val),
        .sum   (sum)
    );

    // An out-of-range B is caught at acceptance and jumps straight to FIN with W left at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        err_d   = err_q;
        done_d  = 1'b0;
        bad_d   = bad_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        step    = 1'b0;
        folded  = fold_word(sum, fold_ovf);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load  = 1'b1;
                    w_d   = '0;
                    err_d = 1'b0;
                    ovf_d = 1'b0;
                    cnt_d = '0;
                    if (bus.B_val >= RADIX_V) begin
                        bad_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        bad_d   = 1'b0;
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                w_d     = folded;
                ovf_d   = fold_ovf;
                state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                err_d   = bad_q | ovf_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            bad_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            bad_q   <= bad_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.W    = w_q;
    assign bus.err  = err_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_word_encoder.sv
// Directed scoreboard bench for word_encoder with RADIX=60 and RADIX=100 instances.
// Expectations track WORD_ENCODER_SATURATE_EN the same way the build does.
module tb_word_encoder;
    import enc_pkg::*;

    typedef struct {
        int                 sel;
        logic [W_WIDTH-1:0] w;
        logic               err;
        int                 lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    word_encoder_if bus0 ();
    word_encoder_if bus1 ();

    word_encoder #(.RADIX(60)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    word_encoder #(.RADIX(100)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int sel, input int a, input int b);
        exp_t e;
        int   radix;
        int   full;
        radix = (sel != 0) ? 100 : 60;
        full  = a * radix + b;
        e.sel = sel;
        if (b >= radix) begin
            e.w   = '0;
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            e.lat = 9;
`ifdef WORD_ENCODER_SATURATE_EN
            if (full > 8191) begin
                e.w   = 13'd8191;
                e.err = 1'b1;
            end else begin
                e.w   = W_WIDTH'(full);
                e.err = 1'b0;
            end
`else
            e.w   = W_WIDTH'(full % 8192);
            e.err = 1'b0;
`endif
        end
        return e;
    endfunction

    task automatic drive(input int sel, input logic st, input int a, input int b);
        if (sel != 0) begin
            bus1.start = st;
            bus1.A_val = AB_WIDTH'(a);
            bus1.B_val = AB_WIDTH'(b);
        end else begin
            bus0.start = st;
            bus0.A_val = AB_WIDTH'(a);
            bus0.B_val = AB_WIDTH'(b);
        end
    endtask

    task automatic sampleOut(input int sel, output logic [W_WIDTH-1:0] w, output logic bz,
                             output logic dn, output logic er);
        if (sel != 0) begin
            w = bus1.W; bz = bus1.busy; dn = bus1.done; er = bus1.err;
        end else begin
            w = bus0.W; bz = bus0.busy; dn = bus0.done; er = bus0.err;
        end
    endtask

    // Present one request for a single cycle and confirm it was accepted and cleared the result.
    task automatic applyStimulus(input int sel, input int a, input int b);
        logic [W_WIDTH-1:0] w;
        logic bz, dn, er;
        @(negedge clk);
        drive(sel, 1'b1, a, b);
        sb.push_back(model(sel, a, b));
        @(negedge clk);
        drive(sel, 1'b0, a, b);
        sampleOut(sel, w, bz, dn, er);
        checkOutput("busy after accept", 32'(bz), 32'd1);
        checkOutput("W cleared on start", 32'(w), 32'd0);
        checkOutput("err cleared on start", 32'(er), 32'd0);
    endtask

    task automatic waitDone(input int sel, input bit glitch);
        exp_t e;
        int   lat = 0;
        int   busyCnt = 1;
        logic [W_WIDTH-1:0] w;
        logic bz, dn, er;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            sampleOut(sel, w, bz, dn, er);
            if (dn) begin
                lat = n;
                break;
            end
            if (bz) busyCnt++;
            if (glitch) drive(sel, (n == 3 || n == 5), 99, 1);
        end
        drive(sel, 1'b0, 99, 1);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{sel: sel, w: '0, err: 1'b0, lat: -1};
        checkOutput("done latency", 32'(lat), 32'(e.lat));
        checkOutput("W at done", 32'(w), 32'(e.w));
        checkOutput("err at done", 32'(er), 32'(e.err));
        checkOutput("busy low at done", 32'(bz), 32'd0);
        checkOutput("busy cycles", 32'(busyCnt), 32'(e.lat));
        @(negedge clk);
        sampleOut(sel, w, bz, dn, er);
        checkOutput("done single cycle", 32'(dn), 32'd0);
        checkOutput("W held after done", 32'(w), 32'(e.w));
        checkOutput("err held after done", 32'(er), 32'(e.err));
    endtask

    task automatic countDone(input int sel, input int cycles, output int cnt);
        logic [W_WIDTH-1:0] w;
        logic bz, dn, er;
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            sampleOut(sel, w, bz, dn, er);
            if (dn) cnt++;
        end
    endtask

    initial begin
        int cnt;
        $display("[TB] word_encoder bench start");
        reset = 1'b0;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("reset W", 32'(bus0.W), 32'd0);
        checkOutput("reset busy", 32'(bus0.busy), 32'd0);
        checkOutput("reset done", 32'(bus0.done), 32'd0);
        checkOutput("reset err", 32'(bus0.err), 32'd0);
        reset = 1'b1;

        applyStimulus(0, 10, 5);
        waitDone(0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("W hold in idle", 32'(bus0.W), 32'd605);

        applyStimulus(0, 127, 59);
        waitDone(0, 1'b0);
        applyStimulus(0, 0, 0);
        waitDone(0, 1'b0);
        applyStimulus(0, 3, 60);
        waitDone(0, 1'b0);

        $display("[TB] starts during busy");
        applyStimulus(0, 20, 7);
        waitDone(0, 1'b1);
        countDone(0, 12, cnt);
        checkOutput("no extra done", 32'(cnt), 32'd0);

        $display("[TB] reset during MUL");
        applyStimulus(0, 50, 9);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort busy", 32'(bus0.busy), 32'd0);
        checkOutput("abort done", 32'(bus0.done), 32'd0);
        checkOutput("abort W", 32'(bus0.W), 32'd0);
        checkOutput("abort err", 32'(bus0.err), 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        countDone(0, 15, cnt);
        checkOutput("no done after abort", 32'(cnt), 32'd0);
        applyStimulus(0, 50, 9);
        waitDone(0, 1'b0);

        $display("[TB] RADIX=100 overflow boundary");
        applyStimulus(1, 127, 99);
        waitDone(1, 1'b0);
        applyStimulus(1, 81, 91);
        waitDone(1, 1'b0);
        applyStimulus(1, 81, 92);
        waitDone(1, 1'b0);
        applyStimulus(1, 12, 34);
        waitDone(1, 1'b0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset clears held W", 32'(bus1.W), 32'd0);
        checkOutput("reset clears held err", 32'(bus1.err), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
